// File: rtl/log_lut_pkg.sv
// ---------------------------------------------------------------------------
// log_lut_pkg
// Shared definitions for the log2 LUT loader: the controller state encoding,
// default RAM geometry and the helper that derives the RAM depth from the
// address width.
// ---------------------------------------------------------------------------
package log_lut_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 20;

  // Number of RAM words addressed by an address bus of the given width.
  function automatic int ramDepth(input int addrWidth);
    return 1 << addrWidth;
  endfunction

  localparam int DEF_RAM_DEPTH = ramDepth(DEF_ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    VERIFY,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/log_lut_csum.sv
// ---------------------------------------------------------------------------
// log_lut_csum
// Clearable modular accumulator. Each enabled cycle both addends are added
// to the running sum; the sum wraps modulo 2^DATA_WIDTH.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear_i       zero the sum (wins over add_en_i)
//   add_en_i      accumulate addend_a_i + addend_b_i this cycle
//   addend_a_i/b_i  values to add
//   sum_o         registered running sum
// ---------------------------------------------------------------------------
module log_lut_csum
  import log_lut_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  add_en_i,
  input  logic [DATA_WIDTH-1:0] addend_a_i,
  input  logic [DATA_WIDTH-1:0] addend_b_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH-1:0] sum_d;

  // Next sum: clearing has priority; carries beyond DATA_WIDTH are dropped
  // so the sum wraps silently.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_en_i) begin
      sum_d = sum_q + addend_a_i + addend_b_i;
    end
  end

  // Sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/log_lut_loader.sv
// ---------------------------------------------------------------------------
// log_lut_loader
// Write-side controller for the log2 lookup RAM. Accepts LUT words over a
// valid/ready stream, writes them two at a time into a dual-port RAM
// (port A even address, port B odd address), then reads the whole RAM back
// and compares a modular checksum of what was written against what was read.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a load (honoured only in IDLE or DONE)
//   in_valid/in_data    incoming LUT word, address order 0..RAM_DEPTH-1
//   in_ready            word accepted this cycle (high only while loading)
//   addr_a/b, data_a/b, we_a/b   registered RAM port A/B controls
//   q_a/q_b             RAM read data, one-cycle registered latency
//   busy                load or verify in progress
//   done                load + verify finished, held until next start
//   error               checksum mismatch, meaningful while done is high
// ---------------------------------------------------------------------------
module log_lut_loader
  import log_lut_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  we_a,
  output logic                  we_b,
  input  logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int RAM_DEPTH = ramDepth(ADDR_WIDTH);
  localparam int NUM_PAIRS = RAM_DEPTH / 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-2:0] LAST_PAIR = (ADDR_WIDTH-1)'(NUM_PAIRS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wordCnt_q, wordCnt_d;
  logic [ADDR_WIDTH-2:0] pairCnt_q, pairCnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addrA_q, addrA_d;
  logic [ADDR_WIDTH-1:0] addrB_q, addrB_d;
  logic [DATA_WIDTH-1:0] dataA_q, dataA_d;
  logic [DATA_WIDTH-1:0] dataB_q, dataB_d;
  logic                  error_q, error_d;

  logic                  handshake;
  logic                  csumClear;
  logic                  wrAddEn;
  logic                  rdAddEn;
  logic [ADDR_WIDTH-2:0] pairNext;
  logic [DATA_WIDTH-1:0] wrSum;
  logic [DATA_WIDTH-1:0] rdSum;

  assign in_ready  = (state_q == LOAD);
  assign handshake = in_valid & in_ready;
  assign pairNext  = pairCnt_q + 1'b1;

  // Next-state and registered-output logic. RAM-side outputs default to an
  // idle bus every cycle, so a write pulse lasts exactly one cycle.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    pairCnt_d = pairCnt_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    addrA_d   = '0;
    addrB_d   = '0;
    dataA_d   = '0;
    dataB_d   = '0;
    error_d   = error_q;
    csumClear = 1'b0;
    wrAddEn   = 1'b0;
    rdAddEn   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          wordCnt_d = '0;
          pairCnt_d = '0;
          hold_d    = '0;
          error_d   = 1'b0;
          csumClear = 1'b1;
        end
      end

      LOAD: begin
        if (handshake) begin
          wrAddEn   = 1'b1;
          wordCnt_d = wordCnt_q + 1'b1;
          if (!wordCnt_q[0]) begin
            hold_d = in_data;
          end else begin
            // Odd word completes a pair: even word from the hold register
            // goes to port A, the current word to port B.
            we_d    = 1'b1;
            addrA_d = {wordCnt_q[ADDR_WIDTH-1:1], 1'b0};
            addrB_d = wordCnt_q;
            dataA_d = hold_q;
            dataB_d = in_data;
          end
          if (wordCnt_q == LAST_WORD) begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        // Pre-load the first read pair so it is on the bus in the first
        // verify cycle.
        state_d = VERIFY;
        addrA_d = {pairCnt_q, 1'b0};
        addrB_d = {pairCnt_q, 1'b1};
      end

      VERIFY: begin
        // Read data lags the address by one cycle, so the pair issued in
        // the previous verify cycle is accumulated now.
        rdAddEn = (pairCnt_q != '0);
        if (pairCnt_q == LAST_PAIR) begin
          state_d = CHECK;
        end else begin
          pairCnt_d = pairNext;
          addrA_d   = {pairNext, 1'b0};
          addrB_d   = {pairNext, 1'b1};
        end
      end

      CHECK: begin
        // The final pair is still in flight, so the comparison uses the
        // read sum including it.
        rdAddEn = 1'b1;
        error_d = (wrSum != (rdSum + q_a + q_b));
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, hold register and registered RAM-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wordCnt_q <= '0;
      pairCnt_q <= '0;
      hold_q    <= '0;
      we_q      <= 1'b0;
      addrA_q   <= '0;
      addrB_q   <= '0;
      dataA_q   <= '0;
      dataB_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      pairCnt_q <= pairCnt_d;
      hold_q    <= hold_d;
      we_q      <= we_d;
      addrA_q   <= addrA_d;
      addrB_q   <= addrB_d;
      dataA_q   <= dataA_d;
      dataB_q   <= dataB_d;
      error_q   <= error_d;
    end
  end

  log_lut_csum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uWriteCsum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (csumClear),
    .add_en_i  (wrAddEn),
    .addend_a_i(in_data),
    .addend_b_i('0),
    .sum_o     (wrSum)
  );

  log_lut_csum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uReadCsum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (csumClear),
    .add_en_i  (rdAddEn),
    .addend_a_i(q_a),
    .addend_b_i(q_b),
    .sum_o     (rdSum)
  );

  assign we_a   = we_q;
  assign we_b   = we_q;
  assign addr_a = addrA_q;
  assign addr_b = addrB_q;
  assign data_a = dataA_q;
  assign data_b = dataB_q;
  assign busy   = (state_q == LOAD) || (state_q == WAIT) ||
                  (state_q == VERIFY) || (state_q == CHECK);
  assign done   = (state_q == DONE);
  assign error  = error_q;

endmodule

// File: tb/tb_log_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_log_lut_loader
// Drives LUT loads into log_lut_loader with a behavioural dual-port RAM
// attached. Expected write pulses and completion events are queued when the
// stimulus issues words; a monitor pops and compares them when the design
// presents a write pulse or raises done.
// ---------------------------------------------------------------------------
module tb_log_lut_loader;

  localparam int AW    = 4;
  localparam int DW    = 20;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          we_a, we_b;
  logic [DW-1:0] q_a, q_b;
  logic          busy, done, error;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] loadWords [DEPTH];
  bit            corruptRd;
  bit            scrambleReq;

  typedef struct {
    int            cyc;
    logic [AW-1:0] aA;
    logic [DW-1:0] dA;
    logic [AW-1:0] aB;
    logic [DW-1:0] dB;
  } wr_t;

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  wr_t   expWr[$];
  done_t expDone[$];
  wr_t   curWr;
  done_t curDone;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  logic prevDone = 1'b0;

  log_lut_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .we_a    (we_a),
    .we_b    (we_b),
    .q_a     (q_a),
    .q_b     (q_b),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp handshakes and expected events.
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural dual-port RAM with registered read; optionally flips bit 0
  // of address 5 on readback, and can be filled with junk between loads.
  always @(posedge clk) begin
    if (scrambleReq) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
    end else begin
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= data_b;
    end
    q_a <= mem[addr_a] ^ DW'(corruptRd && (addr_a == AW'(5)));
    q_b <= mem[addr_b] ^ DW'(corruptRd && (addr_b == AW'(5)));
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Monitor: every write pulse and every rising done is matched against the
  // oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevDone <= 1'b0;
    end else begin
      if (we_a || we_b) begin
        if (expWr.size() == 0) begin
          reportFail("unexpected write", $sformatf("addr_a=%0d addr_b=%0d at cycle %0d, none expected",
                                                   addr_a, addr_b, cycle));
        end else begin
          curWr = expWr.pop_front();
          checkOutput("write cycle", 32'(cycle), 32'(curWr.cyc));
          checkOutput("write enables", 32'({we_a, we_b}), 32'h3);
          checkOutput("write addr_a", 32'(addr_a), 32'(curWr.aA));
          checkOutput("write data_a", 32'(data_a), 32'(curWr.dA));
          checkOutput("write addr_b", 32'(addr_b), 32'(curWr.aB));
          checkOutput("write data_b", 32'(data_b), 32'(curWr.dB));
        end
      end
      if (done && !prevDone) begin
        if (expDone.size() == 0) begin
          reportFail("unexpected done", $sformatf("done rose at cycle %0d, none expected", cycle));
        end else begin
          curDone = expDone.pop_front();
          checkOutput("done cycle", 32'(cycle), 32'(curDone.cyc));
          checkOutput("error at done", 32'(error), 32'(curDone.err));
        end
      end
      prevDone <= done;
    end
  end

  // Reference: the load is in error exactly when the modular sum of the
  // words written differs from the modular sum of the words read back.
  function automatic bit modelError(input bit corrupt);
    longint unsigned sw = 0;
    longint unsigned sr = 0;
    longint unsigned mask = (64'd1 << DW) - 1;
    for (int a = 0; a < DEPTH; a++) begin
      sw += loadWords[a];
      sr += loadWords[a] ^ ((corrupt && a == 5) ? 1 : 0);
    end
    return (sw & mask) != (sr & mask);
  endfunction

  function automatic logic [DW-1:0] modelSum();
    longint unsigned s = 0;
    for (int a = 0; a < DEPTH; a++) s += loadWords[a];
    return DW'(s);
  endfunction

  task automatic scrambleRam();
    scrambleReq = 1'b1;
    @(negedge clk);
    scrambleReq = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'h0);
    checkOutput({tag, " we"}, 32'({we_a, we_b}), 32'h0);
    checkOutput({tag, " addr_a"}, 32'(addr_a), 32'h0);
    checkOutput({tag, " addr_b"}, 32'(addr_b), 32'h0);
    checkOutput({tag, " data_a"}, 32'(data_a), 32'h0);
    checkOutput({tag, " data_b"}, 32'(data_b), 32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    checkOutput({tag, " done"}, 32'(done), 32'h0);
    checkOutput({tag, " error"}, 32'(error), 32'h0);
  endtask

  // gapMode: 0 back-to-back, 1 one idle cycle before every word, 2 random
  // gaps. stopAfter < DEPTH returns after that many handshakes.
  task automatic applyStimulus(input int gapMode, input bit corrupt,
                               input bit startPulses, input int stopAfter);
    int  gaps;
    int  waitCnt;
    int  t;
    bit  expErr;
    expErr    = modelError(corrupt);
    corruptRd = corrupt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after start", 32'(busy), 32'h1);
    checkOutput("done after start", 32'(done), 32'h0);
    checkOutput("error after start", 32'(error), 32'h0);
    for (int k = 0; k < stopAfter; k++) begin
      gaps = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : $urandom_range(0, 2);
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = loadWords[k];
      waitCnt  = 0;
      while (!in_ready && waitCnt < 50) begin
        @(negedge clk);
        waitCnt++;
      end
      if (!in_ready) begin
        reportFail("in_ready timeout", $sformatf("word %0d not accepted", k));
        in_valid = 1'b0;
        return;
      end
      t = cycle;
      if (k % 2 == 1) begin
        expWr.push_back('{cyc: t + 1, aA: AW'(k - 1), dA: loadWords[k - 1],
                          aB: AW'(k), dB: loadWords[k]});
      end
      if (k == DEPTH - 1) begin
        expDone.push_back('{cyc: t + 3 + DEPTH / 2, err: expErr});
      end
      if (startPulses && k == 5) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (stopAfter < DEPTH) return;
    if (startPulses) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitCnt = 0;
    while (!done && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!done) begin
      reportFail("done timeout", "done never rose");
      expWr.delete();
      expDone.delete();
      return;
    end
    @(negedge clk);
    checkOutput("writes outstanding", 32'(expWr.size()), 32'h0);
    checkOutput("done outstanding", 32'(expDone.size()), 32'h0);
    checkOutput("busy in done", 32'(busy), 32'h0);
    checkOutput("done held", 32'(done), 32'h1);
    for (int a = 0; a < DEPTH; a++) begin
      checkOutput($sformatf("ram[%0d]", a), 32'(mem[a]), 32'(loadWords[a]));
    end
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b1;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    corruptRd   = 1'b0;
    scrambleReq = 1'b0;
    #2 rst_n = 1'b0;
    #2 checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] load of ascending words, back-to-back");
    for (int a = 0; a < DEPTH; a++) loadWords[a] = DW'(a);
    scrambleRam();
    applyStimulus(0, 1'b0, 1'b0, DEPTH);

    $display("[TB] same words with in_valid low on alternate cycles");
    scrambleRam();
    applyStimulus(1, 1'b0, 1'b0, DEPTH);

    $display("[TB] all-ones words, checksum wraps");
    for (int a = 0; a < DEPTH; a++) loadWords[a] = '1;
    scrambleRam();
    applyStimulus(0, 1'b0, 1'b0, DEPTH);
    checkOutput("write checksum", 32'(dut.uWriteCsum.sum_q), 32'(modelSum()));
    checkOutput("read checksum", 32'(dut.uReadCsum.sum_q), 32'(modelSum()));
    checkOutput("wrapped checksum", 32'(dut.uReadCsum.sum_q), 32'hFFFF0);

    $display("[TB] random words with corrupted readback");
    for (int a = 0; a < DEPTH; a++) loadWords[a] = DW'($urandom);
    scrambleRam();
    applyStimulus(2, 1'b1, 1'b0, DEPTH);

    $display("[TB] restart from DONE with error set");
    for (int a = 0; a < DEPTH; a++) loadWords[a] = DW'($urandom);
    applyStimulus(2, 1'b0, 1'b0, DEPTH);

    $display("[TB] start pulsed during LOAD and VERIFY");
    for (int a = 0; a < DEPTH; a++) loadWords[a] = DW'($urandom);
    scrambleRam();
    applyStimulus(2, 1'b0, 1'b1, DEPTH);

    $display("[TB] reset after seven handshakes");
    for (int a = 0; a < DEPTH; a++) loadWords[a] = DW'($urandom);
    applyStimulus(0, 1'b0, 1'b0, 7);
    checkOutput("writes before reset", 32'(expWr.size()), 32'h0);
    checkOutput("busy before reset", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("mid-load reset");
    expWr.delete();
    expDone.delete();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fresh load after reset");
    for (int a = 0; a < DEPTH; a++) loadWords[a] = DW'($urandom);
    scrambleRam();
    applyStimulus(2, 1'b0, 1'b0, DEPTH);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/log_lut_loader.md
# log_lut_loader

Write-side controller for the log2 lookup RAM: accepts a stream of LUT words over a valid/ready handshake and writes them into the dual-port RAM two words per cycle (port A even address, port B odd address). After the load it reads the whole RAM back through both ports and compares a modular checksum, so LUT contents can be reprogrammed at run time instead of coming only from a boot-time file. It sits between the configuration path and the RAM's write/read ports.

## Interface
- ADDR_WIDTH, 4, RAM address width; RAM_DEPTH = 2^ADDR_WIDTH words (always even)
- DATA_WIDTH, 20, LUT word width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a load; sampled only in IDLE or DONE
- in_valid  in  1  in_data valid
- in_data  in  DATA_WIDTH  LUT word, address order 0..RAM_DEPTH-1
- in_ready  out  1  loader accepts a word this cycle
- addr_a / addr_b  out  ADDR_WIDTH  RAM port A / B address
- data_a / data_b  out  DATA_WIDTH  RAM port A / B write data
- we_a / we_b  out  1  RAM port A / B write enable
- q_a / q_b  in  DATA_WIDTH  RAM read data, registered, 1-cycle latency
- busy  out  1  load or verify in progress
- done  out  1  load+verify finished; level, held until next start or reset
- error  out  1  checksum mismatch; valid while done=1

## Operation
- States: IDLE, LOAD, WAIT, VERIFY, CHECK, DONE.
- IDLE/DONE + start=1: next cycle enters LOAD. Word counter, hold register, write checksum and read checksum are cleared. done and error are cleared. start in any other state is ignored.
- LOAD: in_ready=1, driven combinationally from state. A handshake is in_valid & in_ready. Word index k counts handshakes.
  - Even k: word goes into the hold register; write checksum += word.
  - Odd k: write checksum += word. In the next cycle we_a=we_b=1, addr_a=k-1, data_a=hold, addr_b=k, data_b=word for exactly one cycle.
  - On the handshake of k = RAM_DEPTH-1, go to WAIT. The final write pulse occurs during WAIT.
- WAIT: in_ready=0. Lasts one cycle, then VERIFY.
- VERIFY: RAM_DEPTH/2 cycles, we_a=we_b=0, address pairs (0,1), (2,3), … are issued one pair per cycle. Each cycle after a pair is issued, read checksum += q_a + q_b. After the last pair, go to CHECK.
- CHECK: one cycle. It accumulates the last q pair and sets error = (write checksum != final read checksum). Next state is DONE.
- DONE: done=1, busy=0, outputs idle.
- Checksums are sums modulo 2^DATA_WIDTH; overflow wraps silently.
- in_valid outside LOAD is ignored; no data is consumed.
- Gaps in in_valid stall progress without limit; there is no timeout.

## Timing
- Reset values: in_ready=0, we_a=we_b=0, addr_a=addr_b=0, data_a=data_b=0, busy=0, done=0, error=0, state IDLE, all counters 0.
- All RAM-side outputs are registered.
- busy=1 in LOAD, WAIT, VERIFY and CHECK.
- Write latency: a write pulse appears 1 cycle after the handshake of the odd word of a pair.
- From the last handshake (cycle T): WAIT at T+1, VERIFY T+2..T+1+RAM_DEPTH/2, CHECK at T+2+RAM_DEPTH/2, done=1 at T+3+RAM_DEPTH/2.
- With ADDR_WIDTH=4: done rises 11 cycles after the last handshake.
- Minimum load time: RAM_DEPTH cycles at full throughput.
- Reset mid-operation: everything returns to reset values immediately. RAM contents are partially written and undefined; no recovery is attempted. The RAM's own q reset to 0 is tolerated because verify never samples q before its first issued read.

## Structure
- Package log_lut_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, VERIFY, CHECK, DONE);
  - default ADDR_WIDTH and DATA_WIDTH constants;
  - RAM_DEPTH derivation.
- Sub-module log_lut_csum: a clearable modular accumulator with add enable and two addend inputs. It is instantiated twice, once for the write checksum and once for the read checksum. The FSM, counters and hold register live in the top module.
- The RAM instance is outside this block. The bench attaches a behavioural dual-port RAM with write enabled and a registered read.

## Test plan
- Load words 0x00000..0x0000F back-to-back after start → 8 write pulses with pairs (0,1)…(14,15). RAM holds k at address k. done=1 exactly 11 cycles after the last handshake. error=0.
- Same data with in_valid low on alternate cycles → identical RAM contents, write pulses only after odd-word handshakes, error=0.
- Words 0xFFFFF ×16 → checksum wraps to 0xFFFF0 on both sides, error=0.
- Bench RAM flips bit 0 of address 5 on readback → done=1 with error=1.
- start pulsed during LOAD and during VERIFY → ignored; the counter is not cleared and done timing is unchanged.
- rst_n low after 7 handshakes → all outputs at reset values in the same cycle. A fresh start after rst_n rises completes a full load with error=0. A second start in DONE clears done and error on the next cycle.
